// File: rtl/fizzbuzz_sequencer.sv
// Configurable fizz/buzz run controller: holds divisor/length config and streams
// one classified index per accepted valid/ready transfer.
module fizzbuzz_sequencer #(
  parameter int unsigned W        = 8,
  parameter int unsigned FIZZ_DEF = 3,
  parameter int unsigned BUZZ_DEF = 5,
  parameter int unsigned LEN_DEF  = 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_fizz,
  input  logic [W-1:0] cfg_buzz,
  input  logic [W-1:0] cfg_len,
  output logic         cfg_ready,
  input  logic         start,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [1:0]   out_code,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] fizz_div_q, fizz_div_d;
  logic [W-1:0] buzz_div_q, buzz_div_d;
  logic [W-1:0] len_q, len_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] fizz_cnt_q, fizz_cnt_d;
  logic [W-1:0] buzz_cnt_q, buzz_cnt_d;

  logic last_c;
  logic xfer_c;
  logic cfg_we_c;

  assign last_c   = (idx_q == len_q - W'(1));
  assign xfer_c   = (state_q == S_RUN) && out_ready;
  assign cfg_we_c = cfg_valid && (state_q == S_IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks the end-of-run transfer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer_c && last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cfg_ready = (state_q == S_IDLE);
    out_valid = (state_q == S_RUN);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    out_idx   = idx_q;
    out_code  = {(buzz_cnt_q == '0), (fizz_cnt_q == '0)};
    out_last  = out_valid && last_c;
  end

  // Config and counter next values; zero-valued fields are stored as 1
  always_comb begin
    fizz_div_d = fizz_div_q;
    buzz_div_d = buzz_div_q;
    len_d      = len_q;
    idx_d      = idx_q;
    fizz_cnt_d = fizz_cnt_q;
    buzz_cnt_d = buzz_cnt_q;
    if (cfg_we_c) begin
      fizz_div_d = (cfg_fizz == '0) ? W'(1) : cfg_fizz;
      buzz_div_d = (cfg_buzz == '0) ? W'(1) : cfg_buzz;
      len_d      = (cfg_len  == '0) ? W'(1) : cfg_len;
    end
    if ((state_q == S_IDLE) && start) begin
      idx_d      = '0;
      fizz_cnt_d = '0;
      buzz_cnt_d = '0;
    end else if (xfer_c && !last_c && !abort) begin
      idx_d      = idx_q + W'(1);
      fizz_cnt_d = (fizz_cnt_q == fizz_div_q - W'(1)) ? '0 : fizz_cnt_q + W'(1);
      buzz_cnt_d = (buzz_cnt_q == buzz_div_q - W'(1)) ? '0 : buzz_cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fizz_div_q <= W'(FIZZ_DEF);
      buzz_div_q <= W'(BUZZ_DEF);
      len_q      <= W'(LEN_DEF);
      idx_q      <= '0;
      fizz_cnt_q <= '0;
      buzz_cnt_q <= '0;
    end else begin
      fizz_div_q <= fizz_div_d;
      buzz_div_q <= buzz_div_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      fizz_cnt_q <= fizz_cnt_d;
      buzz_cnt_q <= buzz_cnt_d;
    end
  end

endmodule

// File: tb/tb_fizzbuzz_sequencer.sv
// Scoreboard bench for fizzbuzz_sequencer: expected items are queued when a run
// is launched and a negedge monitor pops and compares each handshaked item.
module tb_fizzbuzz_sequencer;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] idx;
    logic [1:0]   code;
    logic         last;
  } item_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic [W-1:0] cfg_fizz, cfg_buzz, cfg_len;
  logic         cfg_ready;
  logic         start, abort;
  logic         out_valid, out_ready;
  logic [W-1:0] out_idx;
  logic [1:0]   out_code;
  logic         out_last;
  logic         busy, done;

  item_t exp_q[$];
  int    vectors    = 0;
  int    miscompares = 0;

  fizzbuzz_sequencer #(.W(W), .FIZZ_DEF(3), .BUZZ_DEF(5), .LEN_DEF(100)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_fizz(cfg_fizz), .cfg_buzz(cfg_buzz), .cfg_len(cfg_len),
    .cfg_ready(cfg_ready), .start(start), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_code(out_code), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference classification by plain modulo arithmetic
  function automatic item_t model(input int i, input int f, input int b, input int len);
    item_t it;
    it.idx  = W'(i);
    it.code = {((i % b) == 0), ((i % f) == 0)};
    it.last = (i == len - 1);
    return it;
  endfunction

  task automatic push_run(input int f, input int b, input int len, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model(i, f, b, len));
  endtask

  // Monitor: every handshake consumes one expected item
  always @(negedge clk) begin
    if (out_valid && out_ready && !reset) begin
      item_t got, exp;
      got = '{idx: out_idx, code: out_code, last: out_last};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_item: got idx=%0d code=%b last=%b expected none", out_idx, out_code, out_last);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL item: got idx=%0d code=%b last=%b expected idx=%0d code=%b last=%b",
                   got.idx, got.code, got.last, exp.idx, exp.code, exp.last);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_after_start", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idx(input int n, input int max);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      if (out_valid && out_idx == W'(n)) found = 1'b1;
      else cyc();
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idx: index %0d not seen within %0d cycles", n, max);
    end
  endtask

  task automatic wait_done(input int max);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("done_seen", 32'(found), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("valid_in_done", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
  endtask

  task automatic write_cfg(input int f, input int b, input int len, input bit with_start);
    cfg_valid = 1'b1;
    cfg_fizz  = W'(f);
    cfg_buzz  = W'(b);
    cfg_len   = W'(len);
    start     = with_start;
    cyc();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_fizz = '0; cfg_buzz = '0; cfg_len = '0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    #22 reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    cyc();

    // Default run, full throughput
    push_run(3, 5, 100, 100);
    pulse_start();
    check("first_idx", 32'(out_idx), 32'd0);
    check("first_code", 32'(out_code), 32'b11);
    wait_done(150);

    // Backpressure at index 4
    push_run(3, 5, 100, 100);
    pulse_start();
    wait_idx(4, 20);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx", 32'(out_idx), 32'd4);
      check("stall_code", 32'(out_code), 32'b00);
    end
    cyc();
    out_ready = 1'b1;
    wait_done(150);

    // Abort while item 20 is handshaked
    push_run(3, 5, 100, 21);
    pulse_start();
    wait_idx(20, 40);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cfg_ready", 32'(cfg_ready), 32'd1);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    cyc();

    // Config write while busy is ignored; zero config becomes 1/1/1
    push_run(3, 5, 100, 100);
    pulse_start();
    wait_idx(10, 20);
    check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
    write_cfg(9, 9, 9, 1'b0);
    wait_done(150);
    write_cfg(0, 0, 0, 1'b0);
    push_run(1, 1, 1, 1);
    pulse_start();
    check("len1_last", 32'(out_last), 32'd1);
    wait_done(10);

    // Config and start in the same cycle
    push_run(2, 7, 10, 10);
    write_cfg(2, 7, 10, 1'b1);
    check("cfgstart_busy", 32'(busy), 32'd1);
    wait_done(30);

    // Async reset mid-run, then defaults must be restored
    push_run(2, 7, 10, 10);
    pulse_start();
    wait_idx(5, 10);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    #11 reset = 1'b0;
    cyc();
    push_run(3, 5, 100, 100);
    pulse_start();
    wait_done(150);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
